pong_key_decoder: RTL and testbench
===================================

# pong_key_decoder

Consumes the raw PS/2 set-2 byte stream delivered by the keyboard receiver and turns it into game controls for the pong datapath. Tracks `E0` (extended) and `F0` (break) prefixes with a small state machine, maintains held/released state for the four paddle keys, and generates a single start pulse and a pause toggle. It sits between the PS/2 keyboard front end and the paddle/ball control logic.

## Interface

- `TIMEOUT_CYC`, 2000000, maximum `clk` cycles allowed between a prefix byte and its following byte (20 ms at 100 MHz).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `code`  in  8  received byte; qualified by `code_valid`.
- `code_valid`  in  1  one-cycle strobe; `code` is valid in this cycle.
- `frame_err`  in  1  receiver framing/parity error indication (level or pulse).
- `p1_up`  out  1  left paddle up: W (`1D`) held and S not held.
- `p1_dn`  out  1  left paddle down: S (`1B`) held and W not held.
- `p2_up`  out  1  right paddle up: Up arrow (`E0 75`) held and Down not held.
- `p2_dn`  out  1  right paddle down: Down arrow (`E0 72`) held and Up not held.
- `start_pulse`  out  1  one-cycle pulse on Space (`29`) press.
- `pause`  out  1  pause level; toggles on each P (`4D`) press.
- `unk_cnt`  out  8  saturating count of completed make codes not in the key map.

## Operation

- Prefix FSM states: IDLE, EXT (after `E0`), BRK (after `F0`), EXT_BRK (after `E0 F0`).
- Transitions on `code_valid` only:
  - IDLE: `E0`→EXT, `F0`→BRK, else make(code, ext=0), stay in IDLE.
  - EXT: `F0`→EXT_BRK, `E0`→EXT, else make(code, ext=1)→IDLE.
  - BRK: break(code, ext=0)→IDLE; a prefix byte here aborts to IDLE, no action.
  - EXT_BRK: break(code, ext=1)→IDLE; a prefix byte here aborts to IDLE.
- Held flags: `w_h`, `s_h`, `up_h`, `dn_h`, `sp_h`, `p_h`. A make sets the flag, a break clears it. Make codes with the wrong ext bit (e.g. `75` without `E0`) are treated as unknown keys.
- Paddle outputs are resolved from the held flags: up = up_h & ~dn_h, and down likewise. If both keys of a pair are held, both outputs are 0.
- Typematic repeat:
  - A repeated make of an already-held Space or P has no effect.
  - `start_pulse` fires only on the not-held→held transition of Space.
  - `pause` toggles only on the not-held→held transition of P.
- `unk_cnt` increments on each completed unknown make and saturates at 255. Breaks never increment it.
- `frame_err` high in any cycle:
  - FSM returns to IDLE.
  - All held flags clear, so all paddle outputs go to 0.
  - `pause` and `unk_cnt` are retained.
  - `code_valid` in the same cycle is ignored.

## Timing

- Reset values: all outputs 0, FSM in IDLE, all held flags 0, timeout counter 0.
- Latency: all outputs are registered. They change in the cycle after the `code_valid` that completes a sequence (one `clk` of latency).
- `start_pulse` is exactly one cycle wide.
- `code_valid` may assert on consecutive cycles. Every strobe is consumed; there is no backpressure.
- Reset asserted mid-sequence (e.g. after `E0`) discards the partial sequence. The next byte is decoded from IDLE.

## Configuration

- `KEY_PREFIX_TIMEOUT_EN` defined:
  - A counter runs while the FSM is in EXT, BRK or EXT_BRK. It clears on every `code_valid`.
  - When the count reaches `TIMEOUT_CYC` with no new byte, the FSM returns to IDLE and the partial sequence is discarded. Held flags are unchanged.
- Macro undefined: no counter is built, and prefix states persist indefinitely until the next byte arrives.

## Test plan

- Reset, then bytes `1D` → `p1_up`=1 one cycle later. Then `F0 1D` → `p1_up`=0. Other outputs stay 0 throughout.
- `E0 75`, then `E0 72` → `p2_up` 1→0 while both keys are held, `p2_dn`=0. Then `E0 F0 75` → `p2_dn`=1.
- `29`, `29`, `29` (typematic), then `F0 29`, then `29` → exactly two `start_pulse` cycles. Similarly `4D`, `4D`, `F0 4D`, `4D` → `pause` goes 0→1→0.
- `1C`, `E0 1D`, `F0 33` → `unk_cnt`=2. Then 300 unknown makes → `unk_cnt` holds at 255.
- Hold W and Down, assert `frame_err` for 1 cycle → all paddle outputs 0, `pause` and `unk_cnt` unchanged. Then `75` → counted as unknown, `p2_up`=0.
- With `KEY_PREFIX_TIMEOUT_EN` and `TIMEOUT_CYC`=100: `E0`, idle 150 cycles, `75` → `p2_up`=0 and `unk_cnt`+1. Without the macro, the same stimulus gives `p2_up`=1.

Source files
------------

// File: rtl/pong_key_decoder_if.sv
// Byte/control bundle between the PS/2 receiver side (master) and the pong key decoder (slave).
interface pong_key_decoder_if;
  logic [7:0] code;
  logic       code_valid;
  logic       frame_err;
  logic       p1_up;
  logic       p1_dn;
  logic       p2_up;
  logic       p2_dn;
  logic       start_pulse;
  logic       pause;
  logic [7:0] unk_cnt;

  modport master (
    output code, code_valid, frame_err,
    input  p1_up, p1_dn, p2_up, p2_dn, start_pulse, pause, unk_cnt
  );

  modport slave (
    input  code, code_valid, frame_err,
    output p1_up, p1_dn, p2_up, p2_dn, start_pulse, pause, unk_cnt
  );
endinterface

// File: rtl/pong_key_decoder.sv
// PS/2 set-2 byte stream to pong controls: E0/F0 prefix FSM, held-key flags, start pulse, pause toggle.
// Optional macro KEY_PREFIX_TIMEOUT_EN abandons a prefix sequence after TIMEOUT_CYC idle cycles.
module pong_key_decoder #(
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  pong_key_decoder_if.slave kbd
);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  localparam int K_W  = 0;
  localparam int K_S  = 1;
  localparam int K_UP = 2;
  localparam int K_DN = 3;
  localparam int K_SP = 4;
  localparam int K_P  = 5;

  state_t     state_q, state_d;
  logic [5:0] held_q, held_d;
  logic [5:0] key_hit;
  logic       pause_q, pause_d;
  logic       start_q, start_d;
  logic [7:0] unk_q, unk_d;
  logic       p1_up_q, p1_dn_q, p2_up_q, p2_dn_q;
  logic       is_make, is_break, key_ext, is_prefix;
  logic       timeout_hit;

  assign is_prefix = (kbd.code == 8'hE0) || (kbd.code == 8'hF0);

`ifdef KEY_PREFIX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_hit = (state_q != S_IDLE) && (cnt_q == CW'(TIMEOUT_CYC));

  always_comb begin
    if (kbd.code_valid || kbd.frame_err || state_q == S_IDLE || timeout_hit) cnt_d = '0;
    else                                                                   cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout_hit        = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    is_make  = 1'b0;
    is_break = 1'b0;
    key_ext  = 1'b0;
    if (kbd.frame_err) begin
      state_d = S_IDLE;
    end else if (kbd.code_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (kbd.code == 8'hE0)      state_d = S_EXT;
          else if (kbd.code == 8'hF0) state_d = S_BRK;
          else                        is_make = 1'b1;
        end
        S_EXT: begin
          if (kbd.code == 8'hF0)      state_d = S_EXT_BRK;
          else if (kbd.code == 8'hE0) state_d = S_EXT;
          else begin
            is_make = 1'b1;
            key_ext = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          state_d  = S_IDLE;
          is_break = !is_prefix;
        end
        S_EXT_BRK: begin
          state_d  = S_IDLE;
          is_break = !is_prefix;
          key_ext  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = S_IDLE;
    end
  end

  // A code only maps to a key with the matching extended bit; anything else is unknown.
  always_comb begin
    key_hit       = '0;
    key_hit[K_W]  = !key_ext && (kbd.code == 8'h1D);
    key_hit[K_S]  = !key_ext && (kbd.code == 8'h1B);
    key_hit[K_SP] = !key_ext && (kbd.code == 8'h29);
    key_hit[K_P]  = !key_ext && (kbd.code == 8'h4D);
    key_hit[K_UP] =  key_ext && (kbd.code == 8'h75);
    key_hit[K_DN] =  key_ext && (kbd.code == 8'h72);
  end

  always_comb begin
    held_d  = held_q;
    start_d = 1'b0;
    pause_d = pause_q;
    unk_d   = unk_q;
    if (kbd.frame_err) begin
      held_d = '0;
    end else begin
      if (is_make) begin
        held_d  = held_q | key_hit;
        start_d = key_hit[K_SP] && !held_q[K_SP];
        pause_d = pause_q ^ (key_hit[K_P] && !held_q[K_P]);
        if (key_hit == '0 && unk_q != 8'hFF) unk_d = unk_q + 8'd1;
      end
      if (is_break) held_d = held_q & ~key_hit;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      held_q  <= '0;
      pause_q <= 1'b0;
      start_q <= 1'b0;
      unk_q   <= '0;
      p1_up_q <= 1'b0;
      p1_dn_q <= 1'b0;
      p2_up_q <= 1'b0;
      p2_dn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      pause_q <= pause_d;
      start_q <= start_d;
      unk_q   <= unk_d;
      p1_up_q <= held_d[K_W]  & ~held_d[K_S];
      p1_dn_q <= held_d[K_S]  & ~held_d[K_W];
      p2_up_q <= held_d[K_UP] & ~held_d[K_DN];
      p2_dn_q <= held_d[K_DN] & ~held_d[K_UP];
    end
  end

  assign kbd.p1_up       = p1_up_q;
  assign kbd.p1_dn       = p1_dn_q;
  assign kbd.p2_up       = p2_up_q;
  assign kbd.p2_dn       = p2_dn_q;
  assign kbd.start_pulse = start_q;
  assign kbd.pause       = pause_q;
  assign kbd.unk_cnt     = unk_q;

endmodule

// File: tb/tb_pong_key_decoder.sv
// Directed bench for pong_key_decoder; inputs change and outputs are sampled on the falling clock edge.
module tb_pong_key_decoder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   pulse_cnt;

  pong_key_decoder_if kbd ();

  pong_key_decoder #(.TIMEOUT_CYC(100)) dut (
    .clk (clk),
    .rst (rst),
    .kbd (kbd.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (kbd.start_pulse === 1'b1) pulse_cnt++;

  // Present one byte for one cycle; returns at the falling edge after it was captured.
  task automatic push(input logic [7:0] b);
    kbd.code       = b;
    kbd.code_valid = 1'b1;
    @(negedge clk);
    kbd.code_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    kbd.code_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    kbd.code       = 8'h00;
    kbd.code_valid = 1'b0;
    kbd.frame_err  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({kbd.p1_up, kbd.p1_dn, kbd.p2_up, kbd.p2_dn, kbd.start_pulse, kbd.pause, kbd.unk_cnt} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs got p1u=%b p1d=%b p2u=%b p2d=%b st=%b pa=%b unk=%0d expected all 0",
               kbd.p1_up, kbd.p1_dn, kbd.p2_up, kbd.p2_dn, kbd.start_pulse, kbd.pause, kbd.unk_cnt);
    end
  endtask

  task automatic test_reset_mid_sequence();
    do_reset();
    push(8'hE0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push(8'h75);
    checks++;
    if (kbd.p2_up !== 1'b0 || kbd.unk_cnt !== 8'd1) begin
      failures++;
      $display("FAIL reset_mid_seq got p2_up=%b unk=%0d expected p2_up=0 unk=1", kbd.p2_up, kbd.unk_cnt);
    end
  endtask

  task automatic test_paddle_p1();
    do_reset();
    push(8'h1D);
    checks++;
    if (kbd.p1_up !== 1'b1) begin
      failures++;
      $display("FAIL p1_up_make got %b expected 1", kbd.p1_up);
    end
    push(8'hF0);
    checks++;
    if (kbd.p1_up !== 1'b1) begin
      failures++;
      $display("FAIL p1_up_during_f0 got %b expected 1", kbd.p1_up);
    end
    push(8'h1D);
    checks++;
    if (kbd.p1_up !== 1'b0) begin
      failures++;
      $display("FAIL p1_up_break got %b expected 0", kbd.p1_up);
    end
    checks++;
    if ({kbd.p1_dn, kbd.p2_up, kbd.p2_dn, kbd.start_pulse, kbd.pause, kbd.unk_cnt} !== 13'd0) begin
      failures++;
      $display("FAIL p1_others got p1d=%b p2u=%b p2d=%b st=%b pa=%b unk=%0d expected all 0",
               kbd.p1_dn, kbd.p2_up, kbd.p2_dn, kbd.start_pulse, kbd.pause, kbd.unk_cnt);
    end
    push(8'h1B);
    checks++;
    if (kbd.p1_dn !== 1'b1 || kbd.p1_up !== 1'b0) begin
      failures++;
      $display("FAIL p1_dn_make got dn=%b up=%b expected dn=1 up=0", kbd.p1_dn, kbd.p1_up);
    end
  endtask

  task automatic test_paddle_p2();
    do_reset();
    push(8'hE0);
    push(8'h75);
    checks++;
    if (kbd.p2_up !== 1'b1 || kbd.p2_dn !== 1'b0) begin
      failures++;
      $display("FAIL p2_up_make got up=%b dn=%b expected up=1 dn=0", kbd.p2_up, kbd.p2_dn);
    end
    push(8'hE0);
    push(8'h72);
    checks++;
    if (kbd.p2_up !== 1'b0 || kbd.p2_dn !== 1'b0) begin
      failures++;
      $display("FAIL p2_both_held got up=%b dn=%b expected up=0 dn=0", kbd.p2_up, kbd.p2_dn);
    end
    push(8'hE0);
    push(8'hF0);
    push(8'h75);
    checks++;
    if (kbd.p2_up !== 1'b0 || kbd.p2_dn !== 1'b1) begin
      failures++;
      $display("FAIL p2_up_break got up=%b dn=%b expected up=0 dn=1", kbd.p2_up, kbd.p2_dn);
    end
    checks++;
    if (kbd.unk_cnt !== 8'd0) begin
      failures++;
      $display("FAIL p2_no_unknown got unk=%0d expected 0", kbd.unk_cnt);
    end
  endtask

  task automatic test_back_to_back_typematic();
    do_reset();
    pulse_cnt = 0;
    push(8'h29);
    checks++;
    if (kbd.start_pulse !== 1'b1) begin
      failures++;
      $display("FAIL start_first got %b expected 1", kbd.start_pulse);
    end
    push(8'h29);
    checks++;
    if (kbd.start_pulse !== 1'b0) begin
      failures++;
      $display("FAIL start_width got %b expected 0", kbd.start_pulse);
    end
    push(8'h29);
    push(8'hF0);
    push(8'h29);
    push(8'h29);
    checks++;
    if (kbd.start_pulse !== 1'b1) begin
      failures++;
      $display("FAIL start_after_release got %b expected 1", kbd.start_pulse);
    end
    gap(2);
    checks++;
    if (pulse_cnt !== 2) begin
      failures++;
      $display("FAIL start_pulse_count got %0d expected 2", pulse_cnt);
    end
  endtask

  task automatic test_pause();
    do_reset();
    push(8'h4D);
    checks++;
    if (kbd.pause !== 1'b1) begin
      failures++;
      $display("FAIL pause_first got %b expected 1", kbd.pause);
    end
    push(8'h4D);
    push(8'hF0);
    push(8'h4D);
    checks++;
    if (kbd.pause !== 1'b1) begin
      failures++;
      $display("FAIL pause_typematic got %b expected 1", kbd.pause);
    end
    push(8'h4D);
    checks++;
    if (kbd.pause !== 1'b0) begin
      failures++;
      $display("FAIL pause_second got %b expected 0", kbd.pause);
    end
  endtask

  task automatic test_unknown();
    do_reset();
    push(8'h1C);
    push(8'hE0);
    push(8'h1D);
    push(8'hF0);
    push(8'h33);
    checks++;
    if (kbd.unk_cnt !== 8'd2 || kbd.p1_up !== 1'b0) begin
      failures++;
      $display("FAIL unk_basic got unk=%0d p1_up=%b expected unk=2 p1_up=0", kbd.unk_cnt, kbd.p1_up);
    end
    for (int i = 0; i < 253; i++) push(8'h1C);
    checks++;
    if (kbd.unk_cnt !== 8'd255) begin
      failures++;
      $display("FAIL unk_reach_max got %0d expected 255", kbd.unk_cnt);
    end
    for (int i = 0; i < 47; i++) push(8'h1C);
    checks++;
    if (kbd.unk_cnt !== 8'd255) begin
      failures++;
      $display("FAIL unk_saturate got %0d expected 255", kbd.unk_cnt);
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    push(8'h4D);
    push(8'hF0);
    push(8'h4D);
    push(8'h1C);
    push(8'h1D);
    push(8'hE0);
    push(8'h72);
    checks++;
    if (kbd.p1_up !== 1'b1 || kbd.p2_dn !== 1'b1 || kbd.pause !== 1'b1 || kbd.unk_cnt !== 8'd1) begin
      failures++;
      $display("FAIL ferr_setup got p1u=%b p2d=%b pa=%b unk=%0d expected 1 1 1 1",
               kbd.p1_up, kbd.p2_dn, kbd.pause, kbd.unk_cnt);
    end
    push(8'hE0);
    kbd.frame_err  = 1'b1;
    kbd.code       = 8'hF0;
    kbd.code_valid = 1'b1;
    @(negedge clk);
    kbd.frame_err  = 1'b0;
    kbd.code_valid = 1'b0;
    checks++;
    if ({kbd.p1_up, kbd.p1_dn, kbd.p2_up, kbd.p2_dn} !== 4'd0 || kbd.pause !== 1'b1 || kbd.unk_cnt !== 8'd1) begin
      failures++;
      $display("FAIL ferr_clear got paddles=%b%b%b%b pa=%b unk=%0d expected 0000 1 1",
               kbd.p1_up, kbd.p1_dn, kbd.p2_up, kbd.p2_dn, kbd.pause, kbd.unk_cnt);
    end
    push(8'h75);
    checks++;
    if (kbd.p2_up !== 1'b0 || kbd.unk_cnt !== 8'd2) begin
      failures++;
      $display("FAIL ferr_then_75 got p2_up=%b unk=%0d expected p2_up=0 unk=2", kbd.p2_up, kbd.unk_cnt);
    end
    push(8'h1D);
    checks++;
    if (kbd.p1_up !== 1'b1) begin
      failures++;
      $display("FAIL ferr_byte_ignored got p1_up=%b expected 1", kbd.p1_up);
    end
  endtask

  task automatic test_prefix_timeout();
    logic       exp_up;
    logic [7:0] exp_unk;
`ifdef KEY_PREFIX_TIMEOUT_EN
    exp_up  = 1'b0;
    exp_unk = 8'd1;
`else
    exp_up  = 1'b1;
    exp_unk = 8'd0;
`endif
    do_reset();
    push(8'hE0);
    gap(150);
    push(8'h75);
    checks++;
    if (kbd.p2_up !== exp_up || kbd.unk_cnt !== exp_unk) begin
      failures++;
      $display("FAIL prefix_timeout got p2_up=%b unk=%0d expected p2_up=%b unk=%0d",
               kbd.p2_up, kbd.unk_cnt, exp_up, exp_unk);
    end
    do_reset();
    push(8'hE0);
    gap(60);
    push(8'h75);
    checks++;
    if (kbd.p2_up !== 1'b1) begin
      failures++;
      $display("FAIL prefix_short_gap got p2_up=%b expected 1", kbd.p2_up);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    pulse_cnt = 0;
    test_reset();
    test_reset_mid_sequence();
    test_paddle_p1();
    test_paddle_p2();
    test_back_to_back_typematic();
    test_pause();
    test_unknown();
    test_frame_err();
    test_prefix_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
